// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_adder
//  Brief    : WIDTH-bit ripple adder split into SEG-bit segments, one
//             segment summed per pipeline stage with the segment carry
//             registered into the next stage. Valid/ready on both sides,
//             global stall when the output register is full and not taken.
//  Options  : ADDER_SUB_EN adds the in_sub port (A - B via A + ~B + 1).
//  Revision : 1.0 - initial release
// ============================================================================
module pipelined_adder #(
  parameter int WIDTH = 16,   // must be a multiple of SEG
  parameter int SEG   = 4     // WIDTH/SEG gives 1..8 stages
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
`ifdef ADDER_SUB_EN
  input  logic             in_sub,
`endif
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int STAGES = WIDTH / SEG;
  localparam int LAST   = STAGES - 1;
  localparam int MSB    = WIDTH - 1;

  // Per-stage registers. Stage k holds the sum for segments 0..k, the carry
  // out of segment k and the full operands so later segments can be added.
  // The last stage doubles as the output register.
  logic [WIDTH-1:0] r_a [STAGES];
  logic [WIDTH-1:0] r_b [STAGES];
  logic [WIDTH-1:0] r_s [STAGES];
  logic             r_c [STAGES];
  logic             r_v [STAGES];
  logic             r_ovf;

  // Next-state values for each stage
  logic [WIDTH-1:0] w_a [STAGES];
  logic [WIDTH-1:0] w_b [STAGES];
  logic [WIDTH-1:0] w_s [STAGES];
  logic             w_c [STAGES];
  logic             w_v [STAGES];
  logic             w_ovf;

  logic [SEG:0]     w_seg;
  logic [WIDTH-1:0] w_cur_a;
  logic [WIDTH-1:0] w_cur_b;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;
  logic             w_adv;

  // Subtraction is folded into the operand at entry, so the stages only add
  // and the operation's mode naturally travels with its effective operand B.
`ifdef ADDER_SUB_EN
  assign w_b_eff   = in_sub ? ~in_b : in_b;
  assign w_cin_eff = in_sub | in_cin;
`else
  assign w_b_eff   = in_b;
  assign w_cin_eff = in_cin;
`endif

  // The whole pipe advances unless a result sits at the output untaken
  assign w_adv    = !r_v[LAST] || out_ready;
  assign in_ready = w_adv;

  // Segment adders: stage 0 from the ports, stage k from stage k-1
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_a[k] = '0;
      w_b[k] = '0;
      w_s[k] = '0;
      w_c[k] = 1'b0;
      w_v[k] = 1'b0;
    end
    w_cur_a = in_a;
    w_cur_b = w_b_eff;
    w_seg   = {1'b0, in_a[SEG-1:0]} + {1'b0, w_b_eff[SEG-1:0]}
            + {{SEG{1'b0}}, w_cin_eff};
    w_a[0]  = in_a;
    w_b[0]  = w_b_eff;
    w_s[0][SEG-1:0] = w_seg[SEG-1:0];
    w_c[0]  = w_seg[SEG];
    w_v[0]  = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      w_cur_a = r_a[k-1];
      w_cur_b = r_b[k-1];
      w_seg   = {1'b0, r_a[k-1][k*SEG +: SEG]} + {1'b0, r_b[k-1][k*SEG +: SEG]}
              + {{SEG{1'b0}}, r_c[k-1]};
      w_a[k]  = r_a[k-1];
      w_b[k]  = r_b[k-1];
      w_s[k]  = r_s[k-1];
      w_s[k][k*SEG +: SEG] = w_seg[SEG-1:0];
      w_c[k]  = w_seg[SEG];
      w_v[k]  = r_v[k-1];
    end
    // After the loop w_seg is the MSB segment and w_cur_* its operands
    w_ovf = (w_cur_a[MSB] == w_cur_b[MSB]) && (w_seg[SEG-1] != w_cur_a[MSB]);
  end

  // Stage registers: cleared on reset, frozen while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
        r_c[k] <= 1'b0;
        r_v[k] <= 1'b0;
      end
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= w_a[k];
        r_b[k] <= w_b[k];
        r_s[k] <= w_s[k];
        r_c[k] <= w_c[k];
        r_v[k] <= w_v[k];
      end
      r_ovf <= w_ovf;
    end
  end

  assign out_valid = r_v[LAST];
  assign out_sum   = r_s[LAST];
  assign out_cout  = r_c[LAST];
  assign out_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipelined_adder
//  Brief    : Self-checking bench for pipelined_adder (WIDTH=16, SEG=4)
//             against a whole-word arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_adder;

  localparam int WIDTH  = 16;
  localparam int SEG    = 4;
  localparam int STAGES = WIDTH / SEG;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  int checks   = 0;
  int failures = 0;

  // {ovf, cout, sum} of each accepted operation, in order
  logic [WIDTH+1:0] exp_q[$];

  pipelined_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
`ifdef ADDER_SUB_EN
    .in_sub    (in_sub),
`endif
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: full-word addition, {ovf, cout, sum}
  function automatic logic [WIDTH+1:0] ref_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic cin,
                                               input logic sub);
    logic [WIDTH-1:0] bb;
    logic             cc;
    logic [WIDTH:0]   full;
    logic             ovf;
    bb   = sub ? ~b : b;
    cc   = sub ? 1'b1 : cin;
    full = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, cc};
    ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    return {ovf, full};
  endfunction

  function automatic logic [WIDTH-1:0] rand_word();
    logic [WIDTH-1:0] w;
    case ($urandom_range(0, 7))
      0: w = '1;
      1: w = '0;
      2: w = 16'h8000;
      3: w = 16'h7FFF;
      default: w = WIDTH'($urandom);
    endcase
    return w;
  endfunction

  task automatic drive_random();
    in_valid = 1'b1;
    in_a     = rand_word();
    in_b     = rand_word();
    in_cin   = 1'($urandom_range(0, 1));
`ifdef ADDER_SUB_EN
    in_sub   = 1'($urandom_range(0, 1));
`else
    in_sub   = 1'b0;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b0;
    drive_random();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_sum !== '0 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b sum=%h cout=%b ovf=%b, want all 0",
               out_valid, out_sum, out_cout, out_ovf);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic run_single(input string name, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b, input logic cin,
                            input logic sub, input logic [WIDTH-1:0] e_sum,
                            input logic e_cout, input logic e_ovf);
    int lat;
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_sub = sub;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != STAGES) begin
      failures++;
      $display("FAIL %s_latency: got %0d cycles want %0d", name, lat, STAGES);
    end
    checks++;
    if (out_sum !== e_sum) begin
      failures++;
      $display("FAIL %s_sum: got %h want %h", name, out_sum, e_sum);
    end
    checks++;
    if (out_cout !== e_cout || out_ovf !== e_ovf) begin
      failures++;
      $display("FAIL %s_flags: got cout=%b ovf=%b want cout=%b ovf=%b",
               name, out_cout, out_ovf, e_cout, e_ovf);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_drop: out_valid got %b want 0 after take", name, out_valid);
    end
  endtask

  task automatic test_directed();
    run_single("inc",      16'h1234, 16'h0001, 1'b0, 1'b0, 16'h1235, 1'b0, 1'b0);
    run_single("ripple",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_single("pos_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_single("neg_ovf",  16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_single("cin",      16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);
  endtask

`ifdef ADDER_SUB_EN
  task automatic test_sub();
    run_single("sub",      16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_single("sub_cin",  16'h0009, 16'h0002, 1'b1, 1'b1, 16'h0007, 1'b1, 1'b0);
  endtask
`endif

  task automatic test_back_to_back();
    int sent, got, cyc, first, last;
    logic [WIDTH+1:0] exp;
    exp_q.delete();
    sent = 0; got = 0; cyc = 0; first = -1; last = -1;
    out_ready = 1'b1;
    while (got < 100 && cyc < 400) begin
      if (sent < 100) drive_random();
      else in_valid = 1'b0;
      #1;
      if (sent < 100) begin
        checks++;
        if (in_ready !== 1'b1) begin
          failures++;
          $display("FAIL b2b_in_ready: cycle %0d got %b want 1", cyc, in_ready);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_add(in_a, in_b, in_cin, in_sub));
        sent++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL b2b_extra: unexpected result %h", out_sum);
        end else begin
          exp = exp_q.pop_front();
          if ({out_ovf, out_cout, out_sum} !== exp) begin
            failures++;
            $display("FAIL b2b_result%0d: got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                     got, out_ovf, out_cout, out_sum, exp[WIDTH+1], exp[WIDTH], exp[WIDTH-1:0]);
          end
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 100 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_count: got %0d results (%0d pending) want 100", got, exp_q.size());
    end
    checks++;
    if (last - first != 99) begin
      failures++;
      $display("FAIL b2b_throughput: results spanned %0d cycles want 99", last - first);
    end
  endtask

  task automatic test_stall();
    int acc, got, guard, moved, dup;
    logic [WIDTH+1:0] snap, exp;
    exp_q.delete();
    acc = 0; guard = 0;
    out_ready = 1'b0;
    forever begin
      drive_random();
      #1;
      if (!in_ready || guard > 20) break;
      exp_q.push_back(ref_add(in_a, in_b, in_cin, in_sub));
      acc++; guard++;
      @(posedge clk); #1;
    end
    checks++;
    if (acc != STAGES || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL stall_fill: accepted %0d valid=%b want %0d valid=1", acc, out_valid, STAGES);
    end
    snap = {out_ovf, out_cout, out_sum};
    moved = 0;
    repeat (10) begin
      @(posedge clk); #1;
      drive_random();
      #1;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || {out_ovf, out_cout, out_sum} !== snap)
        moved++;
    end
    checks++;
    if (moved != 0) begin
      failures++;
      $display("FAIL stall_hold: %0d cycles changed, last in_ready=%b valid=%b out=%h want in_ready=0 valid=1 out=%h",
               moved, in_ready, out_valid, {out_ovf, out_cout, out_sum}, snap);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    got = 0; guard = 0;
    while (exp_q.size() > 0 && guard < 40) begin
      #1;
      if (out_valid) begin
        exp = exp_q.pop_front();
        checks++;
        if ({out_ovf, out_cout, out_sum} !== exp) begin
          failures++;
          $display("FAIL stall_result%0d: got %h want %h", got, {out_ovf, out_cout, out_sum}, exp);
        end
        got++;
      end
      @(posedge clk); #1;
      guard++;
    end
    dup = 0;
    repeat (5) begin
      if (out_valid) dup++;
      @(posedge clk); #1;
    end
    checks++;
    if (got != STAGES || dup != 0) begin
      failures++;
      $display("FAIL stall_drain: got %0d results, %0d extra want %0d and 0", got, dup, STAGES);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    exp_q.delete();
    out_ready = 1'b1;
    repeat (3) begin
      drive_random();
      @(posedge clk); #1;
    end
    seen = 0;
    rst = 1'b1;
    drive_random();
    repeat (2) begin
      #1;
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    rst = 1'b0; in_valid = 1'b0;
    repeat (10) begin
      #1;
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_mid_flush: out_valid seen %0d cycles want 0", seen);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_ready: got %b want 1", in_ready);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
    in_sub = 1'b0; out_ready = 1'b0;
    test_reset();
    test_directed();
`ifdef ADDER_SUB_EN
    test_sub();
`endif
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
